// File: rtl/btn_pkg.sv
// Shared constants for the push-button front end: event kinds, hold-FSM
// state encoding and the per-button pending-slot record.
package btn_pkg;

   localparam logic [1:0] EVT_PRESS  = 2'd0;
   localparam logic [1:0] EVT_LONG   = 2'd1;
   localparam logic [1:0] EVT_REPEAT = 2'd2;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_HELD   = 2'd1;
   localparam logic [1:0] ST_REPEAT = 2'd2;

   typedef struct packed {
      logic       valid;
      logic [1:0] kind;
   } slot_t;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/btn_filter.sv
// One button: 3-sample hysteresis debounce plus press / long-hold / auto-repeat FSM.
// Everything advances only on the sample tick; evt is a 1-cycle strobe.
module btn_filter
   import btn_pkg::*;
#(
   parameter int unsigned LONG_TICKS   = 100,
   parameter int unsigned REPEAT_TICKS = 20
) (
   input  logic       cclk,
   input  logic       clr,
   input  logic       tick,
   input  logic       raw,
   output logic       level,
   output logic       evt,
   output logic [1:0] evt_kind
);

   localparam int unsigned   CNT_MAX = max_u(LONG_TICKS, REPEAT_TICKS);
   localparam int unsigned   CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] CNT_SAT = CW'(CNT_MAX);
   localparam logic [CW-1:0] LONG_C  = CW'(LONG_TICKS);
   localparam logic [CW-1:0] REP_C   = CW'(REPEAT_TICKS);

   // Two stored samples; the live raw input is the third of the window.
   logic [1:0]    sr_q, sr_d;
   logic [2:0]    samples;
   logic          level_q, level_d;
   logic          rise, fall;
   logic [1:0]    state_q, state_d;
   logic [CW-1:0] hold_q, hold_d, hold_inc;
   logic          evt_q, evt_d;
   logic [1:0]    kind_q, kind_d;

   always_comb begin
      samples  = {sr_q, raw};
      rise     = tick && (samples == 3'b111) && !level_q;
      fall     = tick && (samples == 3'b000) && level_q;
      sr_d     = tick ? samples[1:0] : sr_q;
      level_d  = level_q;
      if (rise) begin
         level_d = 1'b1;
      end else if (fall) begin
         level_d = 1'b0;
      end
      hold_inc = (hold_q == CNT_SAT) ? hold_q : hold_q + CW'(1);
   end

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      evt_d   = 1'b0;
      kind_d  = kind_q;
      if (tick) begin
         unique case (state_q)
            ST_IDLE: begin
               if (rise) begin
                  state_d = ST_HELD;
                  hold_d  = '0;
                  evt_d   = 1'b1;
                  kind_d  = EVT_PRESS;
               end
            end
            ST_HELD: begin
               if (fall) begin
                  state_d = ST_IDLE;
                  hold_d  = '0;
               end else if (hold_inc == LONG_C) begin
                  state_d = ST_REPEAT;
                  hold_d  = '0;
                  evt_d   = 1'b1;
                  kind_d  = EVT_LONG;
               end else begin
                  hold_d = hold_inc;
               end
            end
            ST_REPEAT: begin
               if (fall) begin
                  state_d = ST_IDLE;
                  hold_d  = '0;
               end else if (hold_inc == REP_C) begin
                  hold_d = '0;
                  evt_d  = 1'b1;
                  kind_d = EVT_REPEAT;
               end else begin
                  hold_d = hold_inc;
               end
            end
            default: begin
               state_d = ST_IDLE;
               hold_d  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge cclk or posedge clr) begin
      if (clr) begin
         sr_q    <= '0;
         level_q <= 1'b0;
         state_q <= ST_IDLE;
         hold_q  <= '0;
         evt_q   <= 1'b0;
         kind_q  <= EVT_PRESS;
      end else begin
         sr_q    <= sr_d;
         level_q <= level_d;
         state_q <= state_d;
         hold_q  <= hold_d;
         evt_q   <= evt_d;
         kind_q  <= kind_d;
      end
   end

   assign level    = level_q;
   assign evt      = evt_q;
   assign evt_kind = kind_q;

endmodule

// File: rtl/button_ctrl.sv
// Push-button front end: sample divider, per-button filters, one pending slot
// per button and a round-robin arbiter feeding a single valid/ready event stream.
module button_ctrl
   import btn_pkg::*;
#(
   parameter int unsigned N_BTN        = 4,
   parameter int unsigned SAMPLE_DIV   = 250000,
   parameter int unsigned LONG_TICKS   = 100,
   parameter int unsigned REPEAT_TICKS = 20
) (
   input  logic                     cclk,
   input  logic                     clr,
   input  logic [N_BTN-1:0]         btn_raw,
   output logic [N_BTN-1:0]         btn_level,
   output logic                     evt_valid,
   input  logic                     evt_ready,
   output logic [$clog2(N_BTN)-1:0] evt_id,
   output logic [1:0]               evt_kind,
   output logic                     evt_overrun
);

   localparam int unsigned   IW        = $clog2(N_BTN);
   localparam int unsigned   DW        = $clog2(SAMPLE_DIV);
   localparam logic [DW-1:0] DIV_LAST  = DW'(SAMPLE_DIV - 1);
   localparam logic [IW-1:0] GRANT_RST = IW'(N_BTN - 1);

   logic [DW-1:0] div_q;
   logic          tick;

   assign tick = (div_q == DIV_LAST);

   always_ff @(posedge cclk or posedge clr) begin
      if (clr) begin
         div_q <= '0;
      end else begin
         div_q <= tick ? '0 : div_q + DW'(1);
      end
   end

   // Raw buttons are asynchronous; two flops before the filter window.
   logic [N_BTN-1:0] sync1_q, sync2_q;

   always_ff @(posedge cclk or posedge clr) begin
      if (clr) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
      end
   end

   logic [N_BTN-1:0] fevt;
   logic [1:0]       fkind [N_BTN];

   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      btn_filter #(
         .LONG_TICKS  (LONG_TICKS),
         .REPEAT_TICKS(REPEAT_TICKS)
      ) u_filter (
         .cclk    (cclk),
         .clr     (clr),
         .tick    (tick),
         .raw     (sync2_q[i]),
         .level   (btn_level[i]),
         .evt     (fevt[i]),
         .evt_kind(fkind[i])
      );
   end

   slot_t         slot_q [N_BTN];
   slot_t         slot_d [N_BTN];
   logic          overrun_q, overrun_d;
   logic          out_valid_q, out_valid_d;
   logic [IW-1:0] out_id_q, out_id_d;
   logic [1:0]    out_kind_q, out_kind_d;
   logic [IW-1:0] grant_q, grant_d;
   logic          win_found;
   logic [IW-1:0] win_idx;
   logic [1:0]    win_kind;
   int unsigned   cand;
   logic          load_ok, load;

   // Search upward from the slot after the last grant, wrapping around.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      win_kind  = EVT_PRESS;
      cand      = 0;
      for (int unsigned k = 1; k <= N_BTN; k++) begin
         cand = (32'(grant_q) + k) % N_BTN;
         if (!win_found && slot_q[cand].valid) begin
            win_found = 1'b1;
            win_idx   = IW'(cand);
            win_kind  = slot_q[cand].kind;
         end
      end
      load_ok = !out_valid_q || evt_ready;
      load    = load_ok && win_found;
   end

   always_comb begin
      overrun_d = overrun_q;
      for (int i = 0; i < N_BTN; i++) begin
         slot_d[i] = slot_q[i];
         if (load && (win_idx == IW'(i))) begin
            slot_d[i].valid = 1'b0;
         end
         if (fevt[i]) begin
            // A slot being drained this cycle may take the new event directly.
            if (slot_q[i].valid && !(load && (win_idx == IW'(i)))) begin
               overrun_d = 1'b1;
            end else begin
               slot_d[i].valid = 1'b1;
               slot_d[i].kind  = fkind[i];
            end
         end
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_id_d    = out_id_q;
      out_kind_d  = out_kind_q;
      grant_d     = grant_q;
      if (load) begin
         out_valid_d = 1'b1;
         out_id_d    = win_idx;
         out_kind_d  = win_kind;
         grant_d     = win_idx;
      end else if (load_ok) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge cclk or posedge clr) begin
      if (clr) begin
         for (int i = 0; i < N_BTN; i++) begin
            slot_q[i] <= '0;
         end
         overrun_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_id_q    <= '0;
         out_kind_q  <= EVT_PRESS;
         grant_q     <= GRANT_RST;
      end else begin
         for (int i = 0; i < N_BTN; i++) begin
            slot_q[i] <= slot_d[i];
         end
         overrun_q   <= overrun_d;
         out_valid_q <= out_valid_d;
         out_id_q    <= out_id_d;
         out_kind_q  <= out_kind_d;
         grant_q     <= grant_d;
      end
   end

   assign evt_valid   = out_valid_q;
   assign evt_id      = out_id_q;
   assign evt_kind    = out_kind_q;
   assign evt_overrun = overrun_q;

endmodule

// File: tb/tb_button_ctrl.sv
// Bench for button_ctrl: table of single-button holds plus hand-written
// sequences; expected events are queued up front and checked at each transfer.
module tb_button_ctrl;

   localparam int unsigned N_BTN        = 4;
   localparam int unsigned SAMPLE_DIV   = 4;
   localparam int unsigned LONG_TICKS   = 8;
   localparam int unsigned REPEAT_TICKS = 3;

   localparam logic [1:0] K_PRESS  = 2'd0;
   localparam logic [1:0] K_LONG   = 2'd1;
   localparam logic [1:0] K_REPEAT = 2'd2;

   logic             cclk      = 1'b0;
   logic             clr       = 1'b1;
   logic [N_BTN-1:0] btn_raw   = '0;
   logic             evt_ready = 1'b0;
   logic [N_BTN-1:0] btn_level;
   logic             evt_valid;
   logic [1:0]       evt_id;
   logic [1:0]       evt_kind;
   logic             evt_overrun;

   always #5 cclk = ~cclk;

   button_ctrl #(
      .N_BTN       (N_BTN),
      .SAMPLE_DIV  (SAMPLE_DIV),
      .LONG_TICKS  (LONG_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS)
   ) dut (
      .cclk       (cclk),
      .clr        (clr),
      .btn_raw    (btn_raw),
      .btn_level  (btn_level),
      .evt_valid  (evt_valid),
      .evt_ready  (evt_ready),
      .evt_id     (evt_id),
      .evt_kind   (evt_kind),
      .evt_overrun(evt_overrun)
   );

   typedef struct {
      logic [1:0] id;
      logic [1:0] kind;
   } evt_t;

   typedef struct {
      int id;
      int hold;
      int n_press;
      int n_long;
      int n_rep;
   } vec_t;

   evt_t exp_q[$];
   int   xfer_cyc[$];
   evt_t mon_e;
   vec_t vecs[6];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;

   always @(posedge cclk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Transfer happens at the next posedge when both are high.
   always @(negedge cclk) begin
      if (!clr && evt_valid && evt_ready) begin
         xfer_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_evt: got id %0d kind %0d, expected none (t=%0t)",
                     evt_id, evt_kind, $time);
         end else begin
            mon_e = exp_q.pop_front();
            check("evt_id", 32'(evt_id), 32'(mon_e.id));
            check("evt_kind", 32'(evt_kind), 32'(mon_e.kind));
         end
      end
   end

   task automatic push_evt(input int id, input logic [1:0] kind);
      evt_t e;
      e.id   = 2'(id);
      e.kind = kind;
      exp_q.push_back(e);
   endtask

   // Hold one raw value for exactly one sample period; returns just after the tick edge.
   task automatic sample(input logic [N_BTN-1:0] v);
      btn_raw = v;
      repeat (SAMPLE_DIV) @(posedge cclk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge cclk);
      #1;
      clr     = 1'b1;
      btn_raw = '0;
      exp_q.delete();
      repeat (2) @(posedge cclk);
      #1;
      clr = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [N_BTN-1:0] m;

      vecs[0] = '{2, 5, 1, 0, 0};   // clean press
      vecs[1] = '{1, 3, 1, 0, 0};   // minimum press
      vecs[2] = '{2, 2, 0, 0, 0};   // too short to qualify
      vecs[3] = '{3, 9, 1, 1, 0};   // long lands on the last held tick
      vecs[4] = '{1, 15, 1, 1, 2};
      vecs[5] = '{0, 20, 1, 1, 3};  // long hold with three repeats

      repeat (2) @(posedge cclk);
      #1;
      check("rst_valid", 32'(evt_valid), 0);
      check("rst_id", 32'(evt_id), 0);
      check("rst_kind", 32'(evt_kind), 0);
      check("rst_overrun", 32'(evt_overrun), 0);
      check("rst_level", 32'(btn_level), 0);
      @(posedge cclk);
      #1;
      clr = 1'b0;

      evt_ready = 1'b1;
      for (int v = 0; v < 6; v++) begin
         m = 4'b0001 << vecs[v].id;
         if (vecs[v].n_press != 0) push_evt(vecs[v].id, K_PRESS);
         if (vecs[v].n_long != 0) push_evt(vecs[v].id, K_LONG);
         for (int r = 0; r < vecs[v].n_rep; r++) push_evt(vecs[v].id, K_REPEAT);
         for (int s = 1; s <= vecs[v].hold; s++) begin
            sample(m);
            if (s == 2) check("level_early", 32'(btn_level[vecs[v].id]), 0);
            if (s == 3) check("level_rise", 32'(btn_level[vecs[v].id]), 1);
         end
         repeat (6) sample('0);
         check("vec_drain", 32'(exp_q.size()), 0);
         check("vec_level_fall", 32'(btn_level[vecs[v].id]), 0);
         check("vec_idle_valid", 32'(evt_valid), 0);
      end

      // Bounce: alternating samples never satisfy the 3-sample window.
      for (int i = 0; i < 10; i++) begin
         sample((i % 2 == 0) ? 4'b0010 : 4'b0000);
         check("bounce_level", 32'(btn_level[1]), 0);
      end
      repeat (3) sample('0);
      push_evt(1, K_PRESS);
      repeat (3) sample(4'b0010);
      check("bounce_settle_level", 32'(btn_level[1]), 1);
      repeat (6) sample('0);
      check("bounce_drain", 32'(exp_q.size()), 0);

      // Simultaneous presses from a fresh pointer: ids 0..3 on consecutive cycles.
      do_reset();
      evt_ready = 1'b1;
      for (int i = 0; i < 4; i++) push_evt(i, K_PRESS);
      xfer_cyc.delete();
      repeat (3) sample(4'hF);
      check("sim_levels", 32'(btn_level), 32'hF);
      repeat (6) sample('0);
      check("sim_drain", 32'(exp_q.size()), 0);
      check("sim_xfers", 32'(xfer_cyc.size()), 4);
      if (xfer_cyc.size() == 4) begin
         for (int i = 1; i < 4; i++) check("sim_b2b", 32'(xfer_cyc[i] - xfer_cyc[i-1]), 1);
      end

      // Backpressure: press stalls on the output, long waits in the slot, repeats drop.
      evt_ready = 1'b0;
      push_evt(3, K_PRESS);
      push_evt(3, K_LONG);
      for (int s = 1; s <= 15; s++) begin
         sample(4'b1000);
         if (s == 4 || s == 13 || s == 15) begin
            check("bp_valid", 32'(evt_valid), 1);
            check("bp_id", 32'(evt_id), 3);
            check("bp_kind", 32'(evt_kind), 32'(K_PRESS));
         end
         if (s == 13) check("bp_no_overrun", 32'(evt_overrun), 0);
         if (s == 15) check("bp_overrun", 32'(evt_overrun), 1);
      end
      repeat (4) sample('0);
      evt_ready = 1'b1;
      repeat (2) sample('0);
      check("bp_drain", 32'(exp_q.size()), 0);
      check("bp_overrun_sticky", 32'(evt_overrun), 1);
      check("bp_idle_valid", 32'(evt_valid), 0);

      // Reset while button 0 sits in REPEAT with press stalled on the output.
      evt_ready = 1'b0;
      repeat (12) sample(4'b0001);
      check("mr_pre_valid", 32'(evt_valid), 1);
      #2;
      clr = 1'b1;
      #1;
      check("mr_valid", 32'(evt_valid), 0);
      check("mr_id", 32'(evt_id), 0);
      check("mr_kind", 32'(evt_kind), 0);
      check("mr_overrun", 32'(evt_overrun), 0);
      check("mr_level", 32'(btn_level), 0);
      exp_q.delete();
      @(posedge cclk);
      #1;
      clr       = 1'b0;
      evt_ready = 1'b1;
      push_evt(0, K_PRESS);
      repeat (3) sample(4'b0001);
      check("mr_level_again", 32'(btn_level[0]), 1);
      repeat (6) sample('0);
      check("mr_drain", 32'(exp_q.size()), 0);
      check("mr_overrun_clear", 32'(evt_overrun), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
